spi_cmd_sequencer: RTL and testbench
====================================

// Module: spi_cmd_sequencer
// PURPOSE
//  Upstream driver for the spi register-interface top (addr/we/write_data/re/read_data).
//  Accepts one SPI transaction request (command, 24-bit address, 32-bit data, read flag)
//  on a valid/ready handshake and plays the register writes to the top in a fixed order.
//  It then runs the enable pulse and a fixed transfer wait, optionally reads DATA_OUT,
//  and returns a response on a valid/ready handshake. One transaction in flight; no queue.
// PARAMETERS
//  XFER_CYCLES  200  cycles enable is held high (full 8+24+32-bit transfer incl. sck divide)
//  CNT_W        8    width of wait counter; must hold XFER_CYCLES-1
// PORTS
//  clk         in   1   single system clock, all logic on rising edge
//  rst         in   1   synchronous, active-high reset
//  req_valid   in   1   request present
//  req_ready   out  1   sequencer can accept (high only in IDLE)
//  req_cmd     in   8   SPI command byte
//  req_addr    in   24  SPI address
//  req_data    in   32  SPI write data
//  req_read    in   1   1 = capture DATA_OUT after transfer
//  rsp_valid   out  1   response present, held until rsp_ready
//  rsp_ready   in   1   consumer accepts response
//  rsp_data    out  32  captured DATA_OUT (0 when req_read=0)
//  busy        out  1   high in every state except IDLE
//  spi_addr    out  3   to spi.addr (0 ENABLE,1 COMMAND,2 ADDRESS,3 DATA_IN,4 DATA_OUT)
//  spi_we      out  1   to spi.we
//  spi_wdata   out  32  to spi.write_data
//  spi_re      out  1   to spi.re
//  spi_rdata   in   32  from spi.read_data
// BEHAVIOUR
//  Reset: state=IDLE, req_ready=1 once released, rsp_valid=0, rsp_data=0, busy=0,
//   spi_addr=0, spi_we=0, spi_wdata=0, spi_re=0, counter=0, latched request cleared.
//  Accept: in IDLE, req_valid&req_ready at edge -> latch cmd/addr/data/read, go WR_CMD.
//  FSM (one cycle each unless noted); spi_* are Moore decodes of registered state:
//   WR_CMD   addr=1 we=1 wdata={24'b0,cmd}
//   WR_ADDR  addr=2 we=1 wdata={8'b0,addr}
//   WR_DATA  addr=3 we=1 wdata=data
//   EN_ON    addr=0 we=1 wdata=1; load counter=0
//   WAIT     we=0 re=0 addr=0; XFER_CYCLES cycles, counter increments, exit at XFER_CYCLES-1
//   EN_OFF   addr=0 we=1 wdata=0; -> READ if req_read else RESP (rsp_data<=0)
//   READ     addr=4 re=1
//   CAPTURE  addr=4 re=1; rsp_data<=spi_rdata at this edge
//   RESP     rsp_valid=1; on rsp_ready -> IDLE (same edge), rsp_valid drops next cycle
//  Idle bus: spi_we=0, spi_re=0, spi_addr=0, spi_wdata=0 in IDLE, WAIT, RESP.
//  Latency: accept edge = cycle 0; rsp_valid first high at cycle 8+XFER_CYCLES (read)
//   or 6+XFER_CYCLES (write-only).
//  req_valid while busy: ignored, not latched; request inputs may change freely after accept.
//  rsp_ready high before RESP: no effect. rsp_ready held high: one-cycle rsp_valid.
//  New request accepted earliest the cycle after RESP exits (IDLE), never same cycle.
//  rst mid-transaction (any state): abort to IDLE, no response issued, enable write not
//   replayed (downstream spi shares rst and clears its own registers).
//  Counter never wraps: XFER_CYCLES in 1..2**CNT_W; XFER_CYCLES=1 gives one WAIT cycle.
// TESTING
//  Reset: hold rst 3 cycles mid-WAIT -> all outputs at reset values, req_ready=1 after.
//  Write-only: cmd=8'h02 addr=24'h00_1234 data=32'hDEAD_BEEF read=0 -> bus writes
//   (1,02),(2,001234),(3,DEADBEEF),(0,1), XFER_CYCLES idle, (0,0); rsp_data=0 at cycle 206.
//  Read: cmd=8'h03 addr=24'h00_1234 read=1 against spi+slave model -> rsp_data equals
//   slave-returned word, rsp_valid at cycle 208 with XFER_CYCLES=200.
//  Backpressure: rsp_ready=0 for 10 cycles -> rsp_valid and rsp_data stable; req_valid
//   during this time not accepted (req_ready=0).
//  Back-to-back: two requests with req_valid always high, rsp_ready always high -> second
//   accepted exactly one cycle after first RESP; bus sequences do not overlap.
//  XFER_CYCLES=1 boundary: WAIT lasts exactly one cycle; EN_ON to EN_OFF spacing = 2 cycles.

Source files
------------

// File: rtl/spi_cmd_sequencer.sv
// Drives the SPI register-interface top with one transaction at a time.
// Sequence: COMMAND, ADDRESS, DATA_IN writes, enable pulse and transfer wait, optional DATA_OUT read, then a response.
module spi_cmd_sequencer #(
    parameter int unsigned XFER_CYCLES = 200,
    parameter int unsigned CNT_W       = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [7:0]  req_cmd_i,
    input  logic [23:0] req_addr_i,
    input  logic [31:0] req_data_i,
    input  logic        req_read_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_data_o,
    output logic        busy_o,
    output logic [2:0]  spi_addr_o,
    output logic        spi_we_o,
    output logic [31:0] spi_wdata_o,
    output logic        spi_re_o,
    input  logic [31:0] spi_rdata_i
);

    localparam int unsigned CMD_W  = 8;
    localparam int unsigned ADDR_W = 24;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_W  = 3;

    localparam logic [REG_W-1:0] REG_ENABLE   = REG_W'(0);
    localparam logic [REG_W-1:0] REG_COMMAND  = REG_W'(1);
    localparam logic [REG_W-1:0] REG_ADDRESS  = REG_W'(2);
    localparam logic [REG_W-1:0] REG_DATA_IN  = REG_W'(3);
    localparam logic [REG_W-1:0] REG_DATA_OUT = REG_W'(4);

    // XFER_CYCLES must lie in 1..2**CNT_W so the last count fits and never wraps.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XFER_CYCLES - 1);

    typedef struct packed {
        logic [CMD_W-1:0]  cmd;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              read;
    } req_t;

    typedef enum logic [3:0] {
        S_IDLE,
        S_WR_CMD,
        S_WR_ADDR,
        S_WR_DATA,
        S_EN_ON,
        S_WAIT,
        S_EN_OFF,
        S_READ,
        S_CAPTURE,
        S_RESP
    } state_t;

    state_t             state_q, state_d;
    req_t               req_q, req_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;
    logic               req_ready_q, req_ready_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               busy_q, busy_d;
    logic [REG_W-1:0]   spi_addr_q, spi_addr_d;
    logic               spi_we_q, spi_we_d;
    logic [DATA_W-1:0]  spi_wdata_q, spi_wdata_d;
    logic               spi_re_q, spi_re_d;

    // State, latched request, counter and registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            req_q       <= '0;
            cnt_q       <= '0;
            rsp_data_q  <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            spi_addr_q  <= '0;
            spi_we_q    <= 1'b0;
            spi_wdata_q <= '0;
            spi_re_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            cnt_q       <= cnt_d;
            rsp_data_q  <= rsp_data_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= busy_d;
            spi_addr_q  <= spi_addr_d;
            spi_we_q    <= spi_we_d;
            spi_wdata_q <= spi_wdata_d;
            spi_re_q    <= spi_re_d;
        end
    end

    // Next state; outputs decode the next state so they line up with the state register.
    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        cnt_d       = cnt_q;
        rsp_data_d  = rsp_data_q;
        req_ready_d = 1'b0;
        rsp_valid_d = 1'b0;
        busy_d      = 1'b0;
        spi_addr_d  = '0;
        spi_we_d    = 1'b0;
        spi_wdata_d = '0;
        spi_re_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_valid_i && req_ready_q) begin
                    req_d.cmd  = req_cmd_i;
                    req_d.addr = req_addr_i;
                    req_d.data = req_data_i;
                    req_d.read = req_read_i;
                    state_d    = S_WR_CMD;
                end
            end
            S_WR_CMD:  state_d = S_WR_ADDR;
            S_WR_ADDR: state_d = S_WR_DATA;
            S_WR_DATA: state_d = S_EN_ON;
            S_EN_ON: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = S_EN_OFF;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_EN_OFF: begin
                if (req_q.read) begin
                    state_d = S_READ;
                end else begin
                    rsp_data_d = '0;
                    state_d    = S_RESP;
                end
            end
            S_READ: state_d = S_CAPTURE;
            S_CAPTURE: begin
                rsp_data_d = spi_rdata_i;
                state_d    = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        req_ready_d = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
        rsp_valid_d = (state_d == S_RESP);

        case (state_d)
            S_WR_CMD: begin
                spi_addr_d  = REG_COMMAND;
                spi_we_d    = 1'b1;
                spi_wdata_d = {{(DATA_W-CMD_W){1'b0}}, req_d.cmd};
            end
            S_WR_ADDR: begin
                spi_addr_d  = REG_ADDRESS;
                spi_we_d    = 1'b1;
                spi_wdata_d = {{(DATA_W-ADDR_W){1'b0}}, req_d.addr};
            end
            S_WR_DATA: begin
                spi_addr_d  = REG_DATA_IN;
                spi_we_d    = 1'b1;
                spi_wdata_d = req_d.data;
            end
            S_EN_ON: begin
                spi_addr_d  = REG_ENABLE;
                spi_we_d    = 1'b1;
                spi_wdata_d = DATA_W'(1);
            end
            S_EN_OFF: begin
                spi_addr_d  = REG_ENABLE;
                spi_we_d    = 1'b1;
                spi_wdata_d = '0;
            end
            S_READ, S_CAPTURE: begin
                spi_addr_d = REG_DATA_OUT;
                spi_re_d   = 1'b1;
            end
            default: begin
                spi_addr_d  = '0;
                spi_we_d    = 1'b0;
                spi_wdata_d = '0;
                spi_re_d    = 1'b0;
            end
        endcase
    end

    assign req_ready_o = req_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign busy_o      = busy_q;
    assign spi_addr_o  = spi_addr_q;
    assign spi_we_o    = spi_we_q;
    assign spi_wdata_o = spi_wdata_q;
    assign spi_re_o    = spi_re_q;

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// Directed bench for spi_cmd_sequencer: a 200-cycle instance with a register/slave model,
// plus a 1-cycle-transfer instance for the short-wait boundary.
module tb_spi_cmd_sequencer;

    localparam int XC = 200;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    // Instance 0 (XFER_CYCLES = 200)
    logic        req_valid, req_ready, req_read, rsp_valid, rsp_ready, busy, spi_we, spi_re;
    logic [7:0]  req_cmd;
    logic [23:0] req_addr;
    logic [31:0] req_data, rsp_data, spi_wdata, spi_rdata;
    logic [2:0]  spi_addr;

    // Instance 1 (XFER_CYCLES = 1)
    logic        req_valid1, req_ready1, req_read1, rsp_valid1, rsp_ready1, busy1, spi_we1, spi_re1;
    logic [7:0]  req_cmd1;
    logic [23:0] req_addr1;
    logic [31:0] req_data1, rsp_data1, spi_wdata1, spi_rdata1;
    logic [2:0]  spi_addr1;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    spi_cmd_sequencer #(.XFER_CYCLES(XC), .CNT_W(8)) u_dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_cmd_i(req_cmd), .req_addr_i(req_addr), .req_data_i(req_data), .req_read_i(req_read),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
        .busy_o(busy), .spi_addr_o(spi_addr), .spi_we_o(spi_we), .spi_wdata_o(spi_wdata),
        .spi_re_o(spi_re), .spi_rdata_i(spi_rdata)
    );

    spi_cmd_sequencer #(.XFER_CYCLES(1), .CNT_W(1)) u_dut1 (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid1), .req_ready_o(req_ready1),
        .req_cmd_i(req_cmd1), .req_addr_i(req_addr1), .req_data_i(req_data1), .req_read_i(req_read1),
        .rsp_valid_o(rsp_valid1), .rsp_ready_i(rsp_ready1), .rsp_data_o(rsp_data1),
        .busy_o(busy1), .spi_addr_o(spi_addr1), .spi_we_o(spi_we1), .spi_wdata_o(spi_wdata1),
        .spi_re_o(spi_re1), .spi_rdata_i(spi_rdata1)
    );

    // Register-interface + slave model: DATA_OUT returns A5A5_0000 ^ {cmd, addr}, registered on re.
    logic [31:0] regs [4];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) regs[i] <= '0;
            spi_rdata <= '0;
        end else begin
            if (spi_we && spi_addr < 3'd4) regs[spi_addr[1:0]] <= spi_wdata;
            if (spi_re && spi_addr == 3'd4)
                spi_rdata <= 32'hA5A5_0000 ^ {regs[1][7:0], regs[2][23:0]};
        end
    end
    assign spi_rdata1 = 32'h0;

    always @(posedge clk) cyc <= cyc + 1;

    logic [2:0]  wa_q[$];
    logic [31:0] wd_q[$];
    int          wt_q[$];
    int          acc_q[$];
    int          rex_q[$];
    logic [31:0] rdq[$];
    int          re_cnt, idle_bad, rv_cnt;
    int          e1t_q[$];
    logic [31:0] e1d_q[$];
    int          acc1_q[$];
    int          rv1_q[$];
    int          w1_cnt;

    always @(negedge clk) begin
        if (spi_we) begin
            wa_q.push_back(spi_addr);
            wd_q.push_back(spi_wdata);
            wt_q.push_back(cyc);
        end
        if (spi_re) re_cnt++;
        if (rsp_valid) rv_cnt++;
        if (!spi_we && !spi_re && (spi_addr != 3'd0 || spi_wdata != 32'd0)) idle_bad++;
        if (spi_we1 && spi_addr1 == 3'd0) begin
            e1t_q.push_back(cyc);
            e1d_q.push_back(spi_wdata1);
        end
        if (busy1 && !spi_we1 && !spi_re1 && !rsp_valid1) w1_cnt++;
        if (rsp_valid1) rv1_q.push_back(cyc);
    end

    always @(posedge clk) begin
        if (!rst && req_valid && req_ready) acc_q.push_back(cyc);
        if (!rst && rsp_valid && rsp_ready) begin
            rex_q.push_back(cyc);
            rdq.push_back(rsp_data);
        end
        if (!rst && req_valid1 && req_ready1) acc1_q.push_back(cyc);
    end

    task automatic clear_logs();
        wa_q.delete(); wd_q.delete(); wt_q.delete();
        acc_q.delete(); rex_q.delete(); rdq.delete();
        re_cnt = 0; idle_bad = 0; rv_cnt = 0;
    endtask

    task automatic send(input logic [7:0] c, input logic [23:0] a, input logic [31:0] d,
                        input logic r, output int acc);
        int n;
        int sz;
        n  = 0;
        sz = acc_q.size();
        req_valid = 1'b1; req_cmd = c; req_addr = a; req_data = d; req_read = r;
        @(negedge clk);
        while (acc_q.size() == sz && n < 50) begin
            @(negedge clk);
            n++;
        end
        req_valid = 1'b0; req_cmd = 8'hFF; req_addr = 24'hFFFFFF; req_data = 32'hFFFF_FFFF; req_read = 1'b0;
        n_checks++;
        if (acc_q.size() == sz) begin
            n_fail++;
            $display("FAIL accept: request not accepted within 50 cycles (got none, required 1)");
            acc = 0;
        end else begin
            acc = acc_q[$];
        end
    endtask

    task automatic wait_rsp(output int seen);
        int n;
        n = 0;
        while (!rsp_valid && n < 1000) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (!rsp_valid) begin
            n_fail++;
            $display("FAIL rsp_timeout: rsp_valid=%0b after 1000 cycles, required 1", rsp_valid);
        end
        seen = cyc;
    endtask

    task automatic test_reset();
        int acc;
        int wsz;
        int bad;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        clear_logs();
        send(8'h02, 24'h000010, 32'h1111_2222, 1'b0, acc);
        repeat (20) @(negedge clk);
        n_checks++;
        if (busy !== 1'b1 || spi_we !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_wait: busy=%0b we=%0b, required busy=1 we=0", busy, spi_we);
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({req_ready, rsp_valid, rsp_data, busy, spi_addr, spi_we, spi_wdata, spi_re} !==
            {1'b1, 1'b0, 32'h0, 1'b0, 3'd0, 1'b0, 32'h0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_values: rdy=%0b rv=%0b rd=%h busy=%0b a=%0d we=%0b wd=%h re=%0b, required 1,0,0,0,0,0,0,0",
                     req_ready, rsp_valid, rsp_data, busy, spi_addr, spi_we, spi_wdata, spi_re);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        wsz = wa_q.size();
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset: req_ready=%0b busy=%0b, required 1 0", req_ready, busy);
        end
        bad = 0;
        repeat (300) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0 || wa_q.size() != wsz) begin
            n_fail++;
            $display("FAIL abort: rsp_valid cycles=%0d new writes=%0d, required 0 0", bad, wa_q.size() - wsz);
        end
    endtask

    task automatic test_read();
        int acc;
        int seen;
        clear_logs();
        send(8'h03, 24'h001234, 32'h0BAD_F00D, 1'b1, acc);
        wait_rsp(seen);
        n_checks++;
        if (seen - acc != 8 + XC) begin
            n_fail++;
            $display("FAIL read_latency: got %0d, required %0d", seen - acc, 8 + XC);
        end
        n_checks++;
        if (rsp_data !== 32'hA6A5_1234) begin
            n_fail++;
            $display("FAIL read_data: got %h, required a6a51234", rsp_data);
        end
        n_checks++;
        if (re_cnt != 2 || wa_q.size() != 5) begin
            n_fail++;
            $display("FAIL read_bus: re cycles=%0d writes=%0d, required 2 5", re_cnt, wa_q.size());
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] d0;
        int bad;
        int asz;
        int wsz;
        d0  = rsp_data;
        asz = acc_q.size();
        wsz = wa_q.size();
        bad = 0;
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_cmd = 8'h9F; req_addr = 24'hABCDEF; req_data = 32'h5555_AAAA; req_read = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_data !== d0 || req_ready !== 1'b0) bad++;
        end
        req_valid = 1'b0;
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL backpressure_hold: unstable cycles=%0d, required 0", bad);
        end
        n_checks++;
        if (acc_q.size() != asz || wa_q.size() != wsz) begin
            n_fail++;
            $display("FAIL backpressure_accept: accepts=%0d writes=%0d, required 0 0",
                     acc_q.size() - asz, wa_q.size() - wsz);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        n_checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rsp_release: rsp_valid=%0b req_ready=%0b busy=%0b, required 0 1 0",
                     rsp_valid, req_ready, busy);
        end
    endtask

    task automatic test_write();
        int acc;
        int seen;
        logic [2:0]  ea [5];
        logic [31:0] ed [5];
        ea = '{3'd1, 3'd2, 3'd3, 3'd0, 3'd0};
        ed = '{32'h0000_0002, 32'h0000_1234, 32'hDEAD_BEEF, 32'h0000_0001, 32'h0000_0000};
        clear_logs();
        send(8'h02, 24'h001234, 32'hDEAD_BEEF, 1'b0, acc);
        wait_rsp(seen);
        n_checks++;
        if (seen - acc != 6 + XC) begin
            n_fail++;
            $display("FAIL write_latency: got %0d, required %0d", seen - acc, 6 + XC);
        end
        n_checks++;
        if (rsp_data !== 32'h0) begin
            n_fail++;
            $display("FAIL write_rsp_data: got %h, required 0", rsp_data);
        end
        n_checks++;
        if (wa_q.size() != 5) begin
            n_fail++;
            $display("FAIL write_count: got %0d writes, required 5", wa_q.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_checks++;
                if (wa_q[i] !== ea[i] || wd_q[i] !== ed[i]) begin
                    n_fail++;
                    $display("FAIL write_%0d: got (%0d,%h), required (%0d,%h)", i, wa_q[i], wd_q[i], ea[i], ed[i]);
                end
            end
            n_checks++;
            if (wt_q[0] != acc + 1 || wt_q[1] != acc + 2 || wt_q[2] != acc + 3 ||
                wt_q[3] != acc + 4 || wt_q[4] != acc + 5 + XC) begin
                n_fail++;
                $display("FAIL write_timing: offsets %0d %0d %0d %0d %0d, required 1 2 3 4 %0d",
                         wt_q[0] - acc, wt_q[1] - acc, wt_q[2] - acc, wt_q[3] - acc, wt_q[4] - acc, 5 + XC);
            end
        end
        n_checks++;
        if (re_cnt != 0 || idle_bad != 0) begin
            n_fail++;
            $display("FAIL write_idle_bus: re cycles=%0d dirty idle cycles=%0d, required 0 0", re_cnt, idle_bad);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int n;
        clear_logs();
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_cmd = 8'h02; req_addr = 24'h0000AB; req_data = 32'h1234_5678; req_read = 1'b0;
        n = 0;
        while (acc_q.size() < 1 && n < 50) begin @(negedge clk); n++; end
        req_cmd = 8'h03; req_addr = 24'h001234; req_data = 32'h0; req_read = 1'b1;
        n = 0;
        while (acc_q.size() < 2 && n < 1000) begin @(negedge clk); n++; end
        req_valid = 1'b0;
        n = 0;
        while (rex_q.size() < 2 && n < 1000) begin @(negedge clk); n++; end
        rsp_ready = 1'b0;
        n_checks++;
        if (acc_q.size() != 2 || rex_q.size() != 2) begin
            n_fail++;
            $display("FAIL b2b_progress: accepts=%0d responses=%0d, required 2 2", acc_q.size(), rex_q.size());
        end else begin
            n_checks++;
            if (acc_q[1] != rex_q[0] + 1) begin
                n_fail++;
                $display("FAIL b2b_gap: second accept %0d cycles after first resp exit, required 1", acc_q[1] - rex_q[0]);
            end
            n_checks++;
            if (rex_q[0] - acc_q[0] != 6 + XC || rex_q[1] - acc_q[1] != 8 + XC) begin
                n_fail++;
                $display("FAIL b2b_latency: got %0d %0d, required %0d %0d",
                         rex_q[0] - acc_q[0], rex_q[1] - acc_q[1], 6 + XC, 8 + XC);
            end
            n_checks++;
            if (rdq[0] !== 32'h0 || rdq[1] !== 32'hA6A5_1234) begin
                n_fail++;
                $display("FAIL b2b_data: got %h %h, required 0 a6a51234", rdq[0], rdq[1]);
            end
            n_checks++;
            if (wa_q.size() != 10 || wt_q[5] != acc_q[1] + 1 || wt_q[4] >= wt_q[5] || wd_q[6] !== 32'h0000_1234) begin
                n_fail++;
                $display("FAIL b2b_bus: writes=%0d second start offset=%0d, required 10 1",
                         wa_q.size(), wt_q.size() > 5 ? wt_q[5] - acc_q[1] : -1);
            end
            n_checks++;
            if (rv_cnt != 2) begin
                n_fail++;
                $display("FAIL b2b_rsp_pulse: rsp_valid cycles=%0d, required 2", rv_cnt);
            end
        end
    endtask

    task automatic test_xfer1();
        int n;
        e1t_q.delete(); e1d_q.delete(); acc1_q.delete(); rv1_q.delete();
        w1_cnt = 0;
        rsp_ready1 = 1'b1;
        req_valid1 = 1'b1; req_cmd1 = 8'h02; req_addr1 = 24'h000042; req_data1 = 32'hCAFE_0001; req_read1 = 1'b0;
        n = 0;
        while (acc1_q.size() < 1 && n < 50) begin @(negedge clk); n++; end
        req_valid1 = 1'b0;
        n = 0;
        while (busy1 && n < 100) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);
        rsp_ready1 = 1'b0;
        n_checks++;
        if (e1t_q.size() != 2 || acc1_q.size() != 1) begin
            n_fail++;
            $display("FAIL x1_enable_writes: got %0d writes %0d accepts, required 2 1", e1t_q.size(), acc1_q.size());
        end else begin
            n_checks++;
            if (e1t_q[1] - e1t_q[0] != 2 || e1d_q[0] !== 32'h1 || e1d_q[1] !== 32'h0) begin
                n_fail++;
                $display("FAIL x1_enable_spacing: got %0d (%h,%h), required 2 (1,0)",
                         e1t_q[1] - e1t_q[0], e1d_q[0], e1d_q[1]);
            end
            n_checks++;
            if (w1_cnt != 1) begin
                n_fail++;
                $display("FAIL x1_wait_len: got %0d, required 1", w1_cnt);
            end
            n_checks++;
            if (rv1_q.size() != 1 || rv1_q[0] - acc1_q[0] != 7) begin
                n_fail++;
                $display("FAIL x1_rsp: rsp_valid cycles=%0d, required 1 at latency 7", rv1_q.size());
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_cmd = '0; req_addr = '0; req_data = '0; req_read = 1'b0; rsp_ready = 1'b0;
        req_valid1 = 1'b0; req_cmd1 = '0; req_addr1 = '0; req_data1 = '0; req_read1 = 1'b0; rsp_ready1 = 1'b0;
        re_cnt = 0; idle_bad = 0; rv_cnt = 0; w1_cnt = 0;
        @(negedge clk);
        test_reset();
        test_read();
        test_backpressure();
        test_write();
        test_back_to_back();
        test_xfer1();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
